// File: rtl/fire5_squeeze_ofm_writer_pkg.sv
// fire5_squeeze_ofm_writer_pkg: shared widths, feature-map word type and writer FSM states
package fire5_squeeze_ofm_writer_pkg;
    localparam int FM_WIDTH  = 16;
    localparam int FM_DSP_NO = 32;
    localparam int FM_WOUT   = 32;
    localparam int FIRE5_PIX = FM_WOUT * FM_WOUT;
    typedef logic [FM_WIDTH-1:0] fm_word_t;
    typedef enum logic [1:0] {IDLE, DRAIN, DONE} wr_state_t;
endpackage

// File: rtl/fire5_squeeze_ofm_writer_addr_gen.sv
// fm_addr_gen: channel/pixel counters producing the channel-major RAM address
module fm_addr_gen
    import fire5_squeeze_ofm_writer_pkg::*;
#(
    parameter int DSP_NO = FM_DSP_NO,
    parameter int PIX    = FIRE5_PIX,
    parameter int ADDR_W = $clog2(DSP_NO * PIX),
    parameter int CH_W   = $clog2(DSP_NO)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_step,
    output logic [CH_W-1:0]   o_ch,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last_ch,
    output logic              o_last_pix
);
    localparam int PIX_W = $clog2(PIX);
    logic [CH_W-1:0]   r_ch;
    logic [PIX_W-1:0]  r_pix;
    logic [PIX_W-1:0]  w_pix_next;
    logic [ADDR_W-1:0] r_base;
    assign o_ch       = r_ch;
    assign o_addr     = r_base;
    assign o_last_ch  = r_ch == CH_W'(DSP_NO - 1);
    assign o_last_pix = r_pix == PIX_W'(PIX - 1);
    assign w_pix_next = o_last_pix ? '0 : r_pix + 1'b1;
    // base walks by one channel plane per step and restarts at the next pixel per vector
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ch   <= '0;
            r_pix  <= '0;
            r_base <= '0;
        end else if (i_step) begin
            r_ch   <= o_last_ch ? '0 : r_ch + 1'b1;
            r_pix  <= o_last_ch ? w_pix_next : r_pix;
            r_base <= o_last_ch ? ADDR_W'(w_pix_next) : r_base + ADDR_W'(PIX);
        end
    end
endmodule

// File: rtl/fire5_squeeze_ofm_writer.sv
// fire5_squeeze_ofm_writer: captures fire5_squeeze ofm vectors and serialises them
// channel-major into the fire5 feature-map RAM, with one pending skid vector
module fire5_squeeze_ofm_writer
    import fire5_squeeze_ofm_writer_pkg::*;
#(
    parameter int WIDTH  = FM_WIDTH,
    parameter int DSP_NO = FM_DSP_NO,
    parameter int WOUT   = FM_WOUT,
    parameter int ADDR_W = $clog2(DSP_NO * WOUT * WOUT)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_fire5_squeeze_sample,
    input  logic [WIDTH-1:0]  i_ofm [0:DSP_NO-1],
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [WIDTH-1:0]  o_ram_wdata,
    output logic              o_ram_feedback,
    output logic              o_writer_done,
    output logic              o_overflow_err
);
    localparam int CH_W = $clog2(DSP_NO);
    wr_state_t         r_state;
    logic [WIDTH-1:0]  r_active [0:DSP_NO-1];
    logic [WIDTH-1:0]  r_pend   [0:DSP_NO-1];
    logic              r_pend_v;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [WIDTH-1:0]  r_wdata;
    logic              r_done;
    logic              r_ovf;
    logic [CH_W-1:0]   w_ch;
    logic [ADDR_W-1:0] w_addr;
    logic              w_last_ch;
    logic              w_last_pix;
    logic              w_start;
    logic              w_drain;
    logic              w_step;
    logic              w_wrap;
    logic              w_finish;
    logic              w_load_act_ofm;
    logic              w_load_act_pend;
    logic              w_load_pend;
    logic              w_overflow;
    fm_addr_gen #(
        .DSP_NO (DSP_NO),
        .PIX    (WOUT * WOUT),
        .ADDR_W (ADDR_W),
        .CH_W   (CH_W)
    ) u_addr_gen (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_step     (w_step),
        .o_ch       (w_ch),
        .o_addr     (w_addr),
        .o_last_ch  (w_last_ch),
        .o_last_pix (w_last_pix)
    );
    // an idle-time sample writes channel 0 straight from the input, so the first write follows by one cycle
    always_comb begin
        w_start         = r_state == IDLE && i_fire5_squeeze_sample;
        w_drain         = r_state == DRAIN;
        w_step          = w_start || w_drain;
        w_wrap          = w_drain && w_last_ch;
        w_finish        = w_wrap && w_last_pix;
        w_load_act_pend = w_wrap && !w_last_pix && r_pend_v;
        w_load_act_ofm  = w_start || (w_wrap && !w_last_pix && !r_pend_v && i_fire5_squeeze_sample);
        w_load_pend     = w_drain && !w_wrap && !r_pend_v && i_fire5_squeeze_sample;
        w_overflow      = w_drain && r_pend_v && i_fire5_squeeze_sample;
    end
    always_ff @(posedge i_clk) begin
        if (w_load_act_ofm) r_active <= i_ofm;
        else if (w_load_act_pend) r_active <= r_pend;
        if (w_load_pend) r_pend <= i_ofm;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_pend_v <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_we   <= w_step;
            r_done <= r_done || w_finish;
            r_ovf  <= r_ovf || w_overflow;
            if (w_step) begin
                r_addr  <= w_addr;
                r_wdata <= w_drain ? r_active[w_ch] : i_ofm[0];
            end
            if (w_load_pend) r_pend_v <= 1'b1;
            else if (w_load_act_pend || w_finish) r_pend_v <= 1'b0;
            case (r_state)
                IDLE:    r_state <= i_fire5_squeeze_sample ? DRAIN : IDLE;
                DRAIN:   r_state <= !w_wrap ? DRAIN : w_last_pix ? DONE :
                                    (r_pend_v || i_fire5_squeeze_sample) ? DRAIN : IDLE;
                default: r_state <= DONE;
            endcase
        end
    end
    assign o_ram_we       = r_we;
    assign o_ram_addr     = r_addr;
    assign o_ram_wdata    = r_wdata;
    assign o_ram_feedback = r_we || r_pend_v;
    assign o_writer_done  = r_done;
    assign o_overflow_err = r_ovf;
endmodule

// File: tb/tb_fire5_squeeze_ofm_writer.sv
// tb_fire5_squeeze_ofm_writer: scoreboard bench for the fire5 squeeze ofm writer
module tb_fire5_squeeze_ofm_writer;
    import fire5_squeeze_ofm_writer_pkg::*;
    localparam int D   = 32;
    localparam int PIX = 1024;
    localparam int AW  = 15;
    typedef struct packed {
        logic [AW-1:0] a;
        fm_word_t      d;
    } wr_t;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sample = 1'b0;
    fm_word_t      ofm [0:D-1];
    fm_word_t      vec [0:D-1];
    logic          we;
    logic [AW-1:0] addr;
    fm_word_t      wdata;
    logic          fb;
    logic          done;
    logic          ovf;
    wr_t           sb [$];
    int            n_pass = 0;
    int            n_total = 0;
    int            n_wr = 0;
    int            run_len = 0;
    int            last_run = 0;
    int            tb_pix = 0;
    time           t_first;
    bit            seen [0:D*PIX-1];

    always #5 clk = ~clk;

    fire5_squeeze_ofm_writer dut (
        .i_clk                  (clk),
        .i_rst_n                (rst_n),
        .i_fire5_squeeze_sample (sample),
        .i_ofm                  (ofm),
        .o_ram_we               (we),
        .o_ram_addr             (addr),
        .o_ram_wdata            (wdata),
        .o_ram_feedback         (fb),
        .o_writer_done          (done),
        .o_overflow_err         (ovf)
    );

    // write monitor: every RAM write must match the head of the scoreboard
    always @(negedge clk) begin
        wr_t exp;
        if (we) begin
            run_len++;
            n_wr++;
            seen[addr] = 1'b1;
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_write addr=%0d data=%0h required=no write", addr, wdata);
            end else begin
                exp = sb.pop_front();
                if (addr !== exp.a || wdata !== exp.d)
                    $display("FAIL ram_write got addr=%0d data=%0h required addr=%0d data=%0h",
                             addr, wdata, exp.a, exp.d);
                else n_pass++;
            end
        end else if (run_len != 0) begin
            last_run = run_len;
            run_len = 0;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic fill_rand();
        for (int c = 0; c < D; c++) vec[c] = fm_word_t'($urandom);
    endtask

    task automatic send(input bit accept);
        ofm = vec;
        sample = 1'b1;
        if (accept) begin
            for (int c = 0; c < D; c++) sb.push_back('{a: AW'(c * PIX + tb_pix), d: vec[c]});
            tb_pix = (tb_pix + 1) % PIX;
        end
        @(negedge clk);
        sample = 1'b0;
    endtask

    task automatic wait_idle(output int run);
        int k = 0;
        while (fb && k < 200) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        run = last_run;
        if (k >= 200) begin
            n_total++;
            $display("FAIL wait_idle timeout feedback=%b required=0", fb);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sample = 1'b0;
        repeat (3) @(negedge clk);
        sb.delete();
        tb_pix = 0;
        n_wr = 0;
        foreach (seen[i]) seen[i] = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int c = 0; c < D; c++) vec[c] = '0;
        ofm = vec;
        repeat (2) @(negedge clk);
        n_total++;
        if ({we, fb, done, ovf} !== 4'b0)
            $display("FAIL reset_flags got we/fb/done/ovf=%b required=0000", {we, fb, done, ovf});
        else n_pass++;
        n_total++;
        if (addr !== '0 || wdata !== '0)
            $display("FAIL reset_bus got addr=%0d data=%0h required 0/0", addr, wdata);
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if (we !== 1'b0 || fb !== 1'b0)
            $display("FAIL idle_after_reset got we=%b fb=%b required 0/0", we, fb);
        else n_pass++;
    endtask

    task automatic test_single();
        int run;
        for (int c = 0; c < D; c++) vec[c] = fm_word_t'(c + 1);
        t_first = $time;
        send(1'b1);
        n_total++;
        if (we !== 1'b1 || fb !== 1'b1)
            $display("FAIL single_latency got we=%b fb=%b required 1/1", we, fb);
        else n_pass++;
        wait_idle(run);
        n_total++;
        if (run !== 32) $display("FAIL single_run got=%0d required=32", run);
        else n_pass++;
        n_total++;
        if (sb.size() !== 0) $display("FAIL single_drained got pending=%0d required=0", sb.size());
        else n_pass++;
    endtask

    task automatic test_second();
        int run;
        int fb_high = 0;
        while ($time < t_first + 2570) begin
            @(negedge clk);
            if (fb) fb_high++;
        end
        fill_rand();
        send(1'b1);
        n_total++;
        if (fb_high !== 0) $display("FAIL gap_feedback got high_cycles=%0d required=0", fb_high);
        else n_pass++;
        wait_idle(run);
        n_total++;
        if (run !== 32) $display("FAIL second_run got=%0d required=32", run);
        else n_pass++;
    endtask

    task automatic test_pending();
        int run;
        fill_rand();
        send(1'b1);
        repeat (9) @(negedge clk);
        fill_rand();
        send(1'b1);
        repeat (9) @(negedge clk);
        n_total++;
        if (ovf !== 1'b0) $display("FAIL ovf_before got=%b required=0", ovf);
        else n_pass++;
        fill_rand();
        send(1'b0);
        n_total++;
        if (ovf !== 1'b1 || fb !== 1'b1)
            $display("FAIL overflow got ovf=%b fb=%b required 1/1", ovf, fb);
        else n_pass++;
        wait_idle(run);
        n_total++;
        if (run !== 64) $display("FAIL pending_run got=%0d required=64", run);
        else n_pass++;
        n_total++;
        if (sb.size() !== 0) $display("FAIL pending_drained got pending=%0d required=0", sb.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int run;
        fill_rand();
        send(1'b1);
        repeat (30) @(negedge clk);
        fill_rand();
        send(1'b1);
        n_total++;
        if (we !== 1'b1) $display("FAIL b2b_no_bubble got we=%b required=1", we);
        else n_pass++;
        wait_idle(run);
        n_total++;
        if (run !== 64) $display("FAIL b2b_run got=%0d required=64", run);
        else n_pass++;
    endtask

    task automatic test_reset_mid_drain();
        int run;
        do_reset();
        fill_rand();
        send(1'b1);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({we, fb} !== 2'b00 || addr !== '0 || wdata !== '0)
            $display("FAIL reset_abort got we=%b fb=%b addr=%0d data=%0h required all 0", we, fb, addr, wdata);
        else n_pass++;
        sb.delete();
        tb_pix = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        fill_rand();
        send(1'b1);
        wait_idle(run);
        n_total++;
        if (run !== 32) $display("FAIL restart_run got=%0d required=32", run);
        else n_pass++;
        n_total++;
        if (sb.size() !== 0) $display("FAIL restart_drained got pending=%0d required=0", sb.size());
        else n_pass++;
    endtask

    task automatic test_full_run();
        int cnt = 0;
        do_reset();
        for (int s = 0; s < PIX; s++) begin
            fill_rand();
            send(1'b1);
            repeat (33) @(negedge clk);
        end
        foreach (seen[i]) if (seen[i]) cnt++;
        n_total++;
        if (done !== 1'b1 || fb !== 1'b0)
            $display("FAIL full_done got done=%b fb=%b required 1/0", done, fb);
        else n_pass++;
        n_total++;
        if (n_wr !== D * PIX || cnt !== D * PIX)
            $display("FAIL full_coverage got writes=%0d distinct=%0d required=%0d", n_wr, cnt, D * PIX);
        else n_pass++;
        n_total++;
        if (sb.size() !== 0 || ovf !== 1'b0)
            $display("FAIL full_clean got pending=%0d ovf=%b required 0/0", sb.size(), ovf);
        else n_pass++;
        fill_rand();
        send(1'b0);
        repeat (40) @(negedge clk);
        n_total++;
        if (n_wr !== D * PIX || done !== 1'b1 || ovf !== 1'b0)
            $display("FAIL done_ignores got writes=%0d done=%b ovf=%b required %0d/1/0", n_wr, done, ovf, D * PIX);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_second();
        test_pending();
        test_back_to_back();
        test_reset_mid_drain();
        test_full_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
